// File: rtl/fpadd_issuer.sv
// Frame accumulator that drives one external fpadd through its reset/done handshake.
// Optional add watchdog (err_timeout port, MAX_WAIT) enabled by FPADD_ISSUER_TIMEOUT_EN.
module fpadd_issuer #(
   parameter int WIDTH = 32
`ifdef FPADD_ISSUER_TIMEOUT_EN
   ,
   parameter int MAX_WAIT = 16
`endif
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [7:0]       out_count,
   output logic             add_reset,
   output logic [WIDTH-1:0] add_dataa,
   output logic [WIDTH-1:0] add_datab,
   input  logic [WIDTH-1:0] add_result,
   input  logic             add_done
`ifdef FPADD_ISSUER_TIMEOUT_EN
   ,
   output logic             err_timeout
`endif
);

   typedef enum logic [2:0] {
      IDLE,
      FIRST,
      START,
      BUSY,
      OUTPUT
   } state_t;

   localparam logic [WIDTH-1:0] QNAN = WIDTH'(32'h7fc0_0000);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] acc;
   logic [7:0]       cnt;
   logic [7:0]       cnt_inc;
   logic             last_q;
   logic             first_q;
   logic             fire;
   logic             done_hit;
   logic             drop;
   logic             tmo;

   assign fire      = in_valid && in_ready;
   assign cnt_inc   = (cnt == 8'hff) ? cnt : cnt + 8'd1;
   assign out_count = cnt;

   // done seen in the first BUSY cycle belongs to the previous add
   assign done_hit  = (state == BUSY) && !first_q && add_done;

`ifdef FPADD_ISSUER_TIMEOUT_EN
   localparam int WW = $clog2(MAX_WAIT) + 1;

   logic [WW-1:0] wcnt;

   assign tmo = (state == BUSY) && !done_hit &&
                (wcnt == WW'(MAX_WAIT - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         wcnt        <= '0;
         drop        <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         if (state == START)
            wcnt <= '0;
         else if (state == BUSY && !done_hit)
            wcnt <= wcnt + WW'(1);
         if (tmo) begin
            err_timeout <= 1'b1;
            drop        <= !last_q;
         end else if (state == FIRST && fire && drop && in_last) begin
            drop <= 1'b0;
         end
      end
   end
`else
   assign tmo  = 1'b0;
   assign drop = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:
            state_nxt = FIRST;
         FIRST:
            if (fire && !drop) begin
               if (cnt == 8'd0)
                  state_nxt = in_last ? OUTPUT : FIRST;
               else
                  state_nxt = START;
            end
         START:
            state_nxt = BUSY;
         BUSY:
            if (done_hit)
               state_nxt = last_q ? OUTPUT : FIRST;
            else if (tmo)
               state_nxt = OUTPUT;
         OUTPUT:
            if (out_ready)
               state_nxt = FIRST;
         default:
            state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      add_reset = reset;
      case (state)
         IDLE:    add_reset = 1'b1;
         FIRST:   in_ready  = !reset;
         START:   add_reset = 1'b1;
         OUTPUT:  out_valid = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc       <= '0;
         cnt       <= '0;
         last_q    <= 1'b0;
         first_q   <= 1'b0;
         out_data  <= '0;
         add_dataa <= '0;
         add_datab <= '0;
      end else begin
         case (state)
            FIRST:
               if (fire && !drop) begin
                  if (cnt == 8'd0) begin
                     acc <= in_data;
                     cnt <= 8'd1;
                     if (in_last)
                        out_data <= in_data;
                  end else begin
                     add_dataa <= acc;
                     add_datab <= in_data;
                     last_q    <= in_last;
                     cnt       <= cnt_inc;
                  end
               end
            START:
               first_q <= 1'b1;
            BUSY: begin
               first_q <= 1'b0;
               if (done_hit) begin
                  acc <= add_result;
                  if (last_q)
                     out_data <= add_result;
               end else if (tmo) begin
                  out_data <= QNAN;
               end
            end
            OUTPUT:
               if (out_ready)
                  cnt <= '0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fpadd_issuer.sv
// Self-checking bench for fpadd_issuer with a behavioural fpadd and a
// real-arithmetic frame-sum reference model.
module tb_fpadd_issuer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_last = 1'b0;
   logic        out_ready = 1'b1;
   logic [31:0] in_data = '0;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] out_data;
   logic [7:0]  out_count;
   logic        add_reset;
   logic [31:0] add_dataa;
   logic [31:0] add_datab;
   logic [31:0] add_result;
   logic        add_done;
`ifdef FPADD_ISSUER_TIMEOUT_EN
   logic        err_timeout;
`endif

   int          checks = 0;
   int          errors = 0;
   int          pulses = 0;
   bit          stall = 1'b0;
   logic [31:0] smp[0:299];

   always #5 clk = ~clk;

   fpadd_issuer #(
      .WIDTH(32)
`ifdef FPADD_ISSUER_TIMEOUT_EN
      ,
      .MAX_WAIT(4)
`endif
   ) dut (
      .clk(clk),
      .reset(reset),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_data(in_data),
      .in_last(in_last),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .out_count(out_count),
      .add_reset(add_reset),
      .add_dataa(add_dataa),
      .add_datab(add_datab),
      .add_result(add_result),
      .add_done(add_done)
`ifdef FPADD_ISSUER_TIMEOUT_EN
      ,
      .err_timeout(err_timeout)
`endif
   );

   function automatic real s2r(input logic [31:0] b);
      logic [63:0] d;
      logic [10:0] e;
      if (b[30:23] == 8'd0)
         return 0.0;
      e = 11'(b[30:23]) + 11'd896;
      d = {b[31], e, b[22:0], 29'b0};
      return $bitstoreal(d);
   endfunction

   function automatic logic [31:0] r2s(input real r);
      logic [63:0] d;
      logic [10:0] e;
      if (r == 0.0)
         return 32'h0;
      d = $realtobits(r);
      e = d[62:52] - 11'd896;
      return {d[63], e[7:0], d[51:29]};
   endfunction

   // fpadd stand-in: done/result stay stale for one cycle after the
   // reset pulse ends, then the sum appears 1..4 cycles later
   int          fa_cnt = 0;
   int          fa_lat = 1;
   logic        fa_done = 1'b0;
   logic        ar_q = 1'b0;
   logic [31:0] fa_res = '0;

   assign add_done   = fa_done;
   assign add_result = fa_res;

   always @(posedge clk) begin
      if (!reset && add_reset)
         pulses <= pulses + 1;
      ar_q <= add_reset;
      if (ar_q) begin
         fa_done <= 1'b0;
         fa_cnt  <= 0;
         fa_lat  <= int'($urandom_range(4, 1));
      end else if (!add_reset && !fa_done && !stall) begin
         fa_cnt <= fa_cnt + 1;
         if (fa_cnt + 1 >= fa_lat) begin
            fa_done <= 1'b1;
            fa_res  <= r2s(s2r(add_dataa) + s2r(add_datab));
         end
      end
   end

   function automatic logic [31:0] ref_sum(input int n);
      real a;
      if (n == 1)
         return smp[0];
      a = 0.0;
      for (int i = 0; i < n; i++)
         a += s2r(smp[i]);
      return r2s(a);
   endfunction

   function automatic logic [31:0] rnd_sample();
      real v;
      v = (real'(int'($urandom_range(128, 0))) - 64.0) * 0.25;
      return r2s(v);
   endfunction

   task automatic push(input logic [31:0] d, input bit last);
      int t;
      t = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      while (!in_ready && t < 300) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL push_ready got=%b exp=1", in_ready);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      @(negedge clk);
   endtask

   task automatic pop(output logic [31:0] d, output logic [7:0] c);
      int t;
      t = 0;
      while (!out_valid && t < 300) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL pop_valid got=%b exp=1", out_valid);
      end
      d = out_data;
      c = out_count;
      @(negedge clk);
   endtask

   task automatic run_frame(input int n, input string name);
      logic [31:0] d;
      logic [7:0]  c;
      logic [31:0] e;
      int          p0;
      int          ec;
      e  = ref_sum(n);
      ec = (n > 255) ? 255 : n;
      p0 = pulses;
      for (int i = 0; i < n; i++)
         push(smp[i], i == n - 1);
      pop(d, c);
      checks++;
      if (d !== e) begin
         errors++;
         $display("FAIL %s data got=%h exp=%h", name, d, e);
      end
      checks++;
      if (c !== 8'(ec)) begin
         errors++;
         $display("FAIL %s count got=%0d exp=%0d", name, c, ec);
      end
      checks++;
      if (pulses - p0 != n - 1) begin
         errors++;
         $display("FAIL %s add_reset_cycles got=%0d exp=%0d",
                  name, pulses - p0, n - 1);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks += 7;
      if (in_ready !== 1'b0) begin
         errors++; $display("FAIL rst_in_ready got=%b exp=0", in_ready);
      end
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid);
      end
      if (out_data !== 32'h0) begin
         errors++; $display("FAIL rst_out_data got=%h exp=0", out_data);
      end
      if (out_count !== 8'h0) begin
         errors++; $display("FAIL rst_out_count got=%0d exp=0", out_count);
      end
      if (add_reset !== 1'b1) begin
         errors++; $display("FAIL rst_add_reset got=%b exp=1", add_reset);
      end
      if (add_dataa !== 32'h0) begin
         errors++; $display("FAIL rst_dataa got=%h exp=0", add_dataa);
      end
      if (add_datab !== 32'h0) begin
         errors++; $display("FAIL rst_datab got=%h exp=0", add_datab);
      end
      reset = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || add_reset !== 1'b0) begin
         errors++;
         $display("FAIL post_rst_first ready=%b add_reset=%b exp 1/0",
                  in_ready, add_reset);
      end
   endtask

   task automatic test_vectors();
      logic [31:0] a[4];
      logic [31:0] b[4];
      a = '{32'h3fc00000, 32'h3fc00000, 32'h3d800000, 32'h3d800000};
      b = '{32'h3fa00000, 32'hbfa00000, 32'h3f800000, 32'h3d800000};
      for (int i = 0; i < 4; i++) begin
         smp[0] = a[i];
         smp[1] = b[i];
         run_frame(2, "pair");
      end
      checks++;
      if (r2s(s2r(32'h3fc00000) + s2r(32'hbfa00000)) !== 32'h3e800000) begin
         errors++;
         $display("FAIL model_pair got=%h exp=3e800000",
                  r2s(s2r(32'h3fc00000) + s2r(32'hbfa00000)));
      end
   endtask

   task automatic test_single();
      logic [31:0] d;
      logic [7:0]  c;
      int          p0;
      p0 = pulses;
      push(32'h40490fdb, 1'b1);
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL single_latency out_valid got=%b exp=1", out_valid);
      end
      pop(d, c);
      checks += 3;
      if (d !== 32'h40490fdb) begin
         errors++; $display("FAIL single_data got=%h exp=40490fdb", d);
      end
      if (c !== 8'd1) begin
         errors++; $display("FAIL single_count got=%0d exp=1", c);
      end
      if (pulses != p0) begin
         errors++;
         $display("FAIL single_pulses got=%0d exp=0", pulses - p0);
      end
   endtask

   task automatic test_backpressure();
      int t;
      out_ready = 1'b0;
      smp[0] = 32'h3fc00000;
      smp[1] = 32'h3fa00000;
      smp[2] = 32'hbfa00000;
      for (int i = 0; i < 3; i++)
         push(smp[i], i == 2);
      t = 0;
      while (!out_valid && t < 300) begin
         @(negedge clk);
         t++;
      end
      in_valid = 1'b1;
      in_data  = 32'h3f800000;
      in_last  = 1'b1;
      checks++;
      if (out_count !== 8'd3) begin
         errors++; $display("FAIL bp_count got=%0d exp=3", out_count);
      end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (out_valid !== 1'b1 || out_data !== ref_sum(3) ||
             in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold cyc=%0d valid=%b data=%h ready=%b exp 1/%h/0",
                     i, out_valid, out_data, in_ready, ref_sum(3));
         end
         @(negedge clk);
      end
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL bp_release got=%b exp=0", out_valid);
      end
   endtask

   task automatic test_reset_busy();
      push(32'h3fc00000, 1'b0);
      push(32'h3fa00000, 1'b0);
      @(negedge clk);
      checks++;
      if (add_reset !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL busy_state add_reset=%b ready=%b exp 0/0",
                  add_reset, in_ready);
      end
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || add_reset !== 1'b1 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset valid=%b add_reset=%b ready=%b exp 0/1/0",
                  out_valid, add_reset, in_ready);
      end
      reset = 1'b0;
      @(negedge clk);
      @(negedge clk);
      smp[0] = 32'h3d800000;
      smp[1] = 32'h3d800000;
      run_frame(2, "after_reset");
   endtask

   task automatic test_random();
      int n;
      for (int f = 0; f < 25; f++) begin
         n = int'($urandom_range(6, 1));
         for (int i = 0; i < n; i++)
            smp[i] = rnd_sample();
         run_frame(n, "random");
      end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 300; i++)
         smp[i] = rnd_sample();
      run_frame(300, "saturate");
   endtask

`ifdef FPADD_ISSUER_TIMEOUT_EN
   task automatic test_timeout();
      logic [31:0] d;
      logic [7:0]  c;
      stall = 1'b1;
      push(32'h3f800000, 1'b0);
      push(32'h3f800000, 1'b0);
      pop(d, c);
      checks += 3;
      if (d !== 32'h7fc00000) begin
         errors++; $display("FAIL tmo_data got=%h exp=7fc00000", d);
      end
      if (c !== 8'd2) begin
         errors++; $display("FAIL tmo_count got=%0d exp=2", c);
      end
      if (err_timeout !== 1'b1) begin
         errors++; $display("FAIL tmo_flag got=%b exp=1", err_timeout);
      end
      stall = 1'b0;
      push(32'h3f800000, 1'b1);
      smp[0] = 32'h40000000;
      run_frame(1, "post_timeout");
      checks++;
      if (err_timeout !== 1'b1) begin
         errors++; $display("FAIL tmo_sticky got=%b exp=1", err_timeout);
      end
   endtask
`endif

   initial begin
      #600000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_vectors();
      test_single();
      test_backpressure();
      test_reset_busy();
      test_random();
      test_saturation();
`ifdef FPADD_ISSUER_TIMEOUT_EN
      test_timeout();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
